// File: rtl/gemm_ctrl_pkg.sv
// Shared types for the PE array controller: FSM states, PE mode codes, phase sequencing.
`ifndef M_END_BITWIDTH
`define M_END_BITWIDTH 2
`endif

package gemm_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    COMPUTE,
    REDUCE,
    DRAIN,
    DONE
  } state_t;

  localparam logic [`M_END_BITWIDTH-1:0] M_HOLD = 2'b00;
  localparam logic [`M_END_BITWIDTH-1:0] M_ACC  = 2'b01;
  localparam logic [`M_END_BITWIDTH-1:0] M_PASS = 2'b10;

  // nz = {drain, reduce, compute, load_w} non-zero flags; skips empty phases after cur
  function automatic state_t next_phase(input state_t cur, input logic [3:0] nz);
    if (cur == IDLE && nz[0]) return LOAD_W;
    if ((cur == IDLE || cur == LOAD_W) && nz[1]) return COMPUTE;
    if ((cur inside {IDLE, LOAD_W, COMPUTE}) && nz[2]) return REDUCE;
    if ((cur inside {IDLE, LOAD_W, COMPUTE, REDUCE}) && nz[3]) return DRAIN;
    return DONE;
  endfunction

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Tile request, stream handshakes and broadcast PE controls; master drives requests,
// slave (the controller) returns readies and PE register strobes.
interface pe_array_ctrl_if #(
  parameter int CNT_W = 16
);
  logic                        start;
  logic [CNT_W-1:0]            cfg_w_len;
  logic [CNT_W-1:0]            cfg_k_len;
  logic [CNT_W-1:0]            cfg_red_len;
  logic [CNT_W-1:0]            cfg_drain_len;
  logic                        w_valid;
  logic                        in_valid;
  logic                        out_ready;

  logic                        weight_reg_en;
  logic                        weight_reg_r0w1;
  logic                        input_reg_en;
  logic                        input_reg_r0w1;
  logic                        rand_num_reg_en;
  logic                        rand_num_reg_r0w1;
  logic                        output_num_reg_en;
  logic                        output_num_reg_r0w1;
  logic [`M_END_BITWIDTH-1:0]  M_end;
  logic                        w_ready;
  logic                        in_ready;
  logic                        out_valid;
  logic                        busy;
  logic                        done;

  modport master (
    output start, cfg_w_len, cfg_k_len, cfg_red_len, cfg_drain_len,
           w_valid, in_valid, out_ready,
    input  weight_reg_en, weight_reg_r0w1, input_reg_en, input_reg_r0w1,
           rand_num_reg_en, rand_num_reg_r0w1, output_num_reg_en, output_num_reg_r0w1,
           M_end, w_ready, in_ready, out_valid, busy, done
  );

  modport slave (
    input  start, cfg_w_len, cfg_k_len, cfg_red_len, cfg_drain_len,
           w_valid, in_valid, out_ready,
    output weight_reg_en, weight_reg_r0w1, input_reg_en, input_reg_r0w1,
           rand_num_reg_en, rand_num_reg_r0w1, output_num_reg_en, output_num_reg_r0w1,
           M_end, w_ready, in_ready, out_valid, busy, done
  );
endinterface

// File: rtl/beat_cnt.sv
// Phase beat counter; tc flags the accepted beat that completes len, and the count
// self-clears on that edge so it never wraps. No latency beyond the register.
module beat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] len,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  assign tc = inc && (cnt == len - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || tc) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pe_array_ctrl.sv
// Sequences one GEMM tile through LOAD_W/COMPUTE/REDUCE/DRAIN; controls are a zero-latency
// decode of state and the live valid/ready, so stalls freeze the counter and hold the PEs.
module pe_array_ctrl
  import gemm_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  pe_array_ctrl_if.slave bus
);

  state_t state, state_nxt;

  logic [CNT_W-1:0] w_len_q, k_len_q, r_len_q, d_len_q;
  logic [3:0]       nz_q, nz_in;
  logic             cnt_clr, cnt_inc, cnt_tc;
  logic [CNT_W-1:0] cnt_len;

  logic                       weight_reg_en, weight_reg_r0w1;
  logic                       input_reg_en, input_reg_r0w1;
  logic                       rand_num_reg_en, rand_num_reg_r0w1;
  logic                       output_num_reg_en, output_num_reg_r0w1;
  logic [`M_END_BITWIDTH-1:0] M_end;
  logic                       w_ready, in_ready, out_valid, busy, done;

  assign nz_in = {|bus.cfg_drain_len, |bus.cfg_red_len, |bus.cfg_k_len, |bus.cfg_w_len};
  assign nz_q  = {|d_len_q, |r_len_q, |k_len_q, |w_len_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      w_len_q <= '0;
      k_len_q <= '0;
      r_len_q <= '0;
      d_len_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start) begin
        w_len_q <= bus.cfg_w_len;
        k_len_q <= bus.cfg_k_len;
        r_len_q <= bus.cfg_red_len;
        d_len_q <= bus.cfg_drain_len;
      end
    end
  end

  assign cnt_clr = (state == IDLE) && bus.start;

  always_comb begin
    state_nxt           = state;
    cnt_inc             = 1'b0;
    cnt_len             = '0;
    weight_reg_en       = 1'b0;
    weight_reg_r0w1     = 1'b0;
    input_reg_en        = 1'b0;
    input_reg_r0w1      = 1'b0;
    rand_num_reg_en     = 1'b0;
    rand_num_reg_r0w1   = 1'b0;
    output_num_reg_en   = 1'b0;
    output_num_reg_r0w1 = 1'b0;
    M_end               = M_HOLD;
    w_ready             = 1'b0;
    in_ready            = 1'b0;
    out_valid           = 1'b0;
    done                = 1'b0;
    busy                = (state != IDLE);

    unique case (state)
      IDLE: begin
        if (bus.start) state_nxt = next_phase(IDLE, nz_in);
      end
      LOAD_W: begin
        w_ready         = 1'b1;
        weight_reg_en   = bus.w_valid;
        weight_reg_r0w1 = bus.w_valid;
        cnt_inc         = bus.w_valid;
        cnt_len         = w_len_q;
        if (cnt_tc) state_nxt = next_phase(LOAD_W, nz_q);
      end
      COMPUTE: begin
        in_ready            = 1'b1;
        M_end               = M_ACC;
        input_reg_en        = bus.in_valid;
        input_reg_r0w1      = bus.in_valid;
        rand_num_reg_en     = bus.in_valid;
        rand_num_reg_r0w1   = bus.in_valid;
        output_num_reg_en   = bus.in_valid;
        output_num_reg_r0w1 = bus.in_valid;
        cnt_inc             = bus.in_valid;
        cnt_len             = k_len_q;
        if (cnt_tc) state_nxt = next_phase(COMPUTE, nz_q);
      end
      REDUCE: begin
        M_end               = M_PASS;
        output_num_reg_en   = 1'b1;
        output_num_reg_r0w1 = 1'b1;
        cnt_inc             = 1'b1;
        cnt_len             = r_len_q;
        if (cnt_tc) state_nxt = next_phase(REDUCE, nz_q);
      end
      DRAIN: begin
        out_valid         = 1'b1;
        output_num_reg_en = 1'b1;
        cnt_inc           = bus.out_ready;
        cnt_len           = d_len_q;
        if (cnt_tc) state_nxt = next_phase(DRAIN, nz_q);
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  beat_cnt #(
    .CNT_W (CNT_W)
  ) u_beat_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .len   (cnt_len),
    .tc    (cnt_tc)
  );

  assign bus.weight_reg_en       = weight_reg_en;
  assign bus.weight_reg_r0w1     = weight_reg_r0w1;
  assign bus.input_reg_en        = input_reg_en;
  assign bus.input_reg_r0w1      = input_reg_r0w1;
  assign bus.rand_num_reg_en     = rand_num_reg_en;
  assign bus.rand_num_reg_r0w1   = rand_num_reg_r0w1;
  assign bus.output_num_reg_en   = output_num_reg_en;
  assign bus.output_num_reg_r0w1 = output_num_reg_r0w1;
  assign bus.M_end               = M_end;
  assign bus.w_ready             = w_ready;
  assign bus.in_ready            = in_ready;
  assign bus.out_valid           = out_valid;
  assign bus.busy                = busy;
  assign bus.done                = done;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Bench for pe_array_ctrl: per-cycle expected output vectors queued at drive time, checked at negedge.
module tb_pe_array_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pe_array_ctrl_if #(.CNT_W(16)) bus ();

  pe_array_ctrl #(.CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [14:0] exp_q[$];
  logic [15:0] t_w, t_k, t_r, t_d;
  logic [14:0] obs;

  // {M_end, w_ready, in_ready, out_valid, busy, done, weight en/w, input en/w, rand en/w, output en/w}
  assign obs = {bus.M_end, bus.w_ready, bus.in_ready, bus.out_valid, bus.busy, bus.done,
                bus.weight_reg_en, bus.weight_reg_r0w1, bus.input_reg_en, bus.input_reg_r0w1,
                bus.rand_num_reg_en, bus.rand_num_reg_r0w1,
                bus.output_num_reg_en, bus.output_num_reg_r0w1};

  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s @%0t: got %b want %b", tag, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) chk("outputs", obs, exp_q.pop_front());
  end

  // phase 0..3 = LOAD_W, COMPUTE, REDUCE, DRAIN; 4 = DONE
  function automatic logic [14:0] ev(input int ph, input logic v);
    case (ph)
      0: return {2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, v, v, 6'b000000};
      1: return {2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, v, v, v, v, v, v};
      2: return {2'b10, 3'b000, 1'b1, 1'b0, 2'b00, 4'b0000, 2'b11};
      3: return {2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b000000, 2'b10};
      4: return {2'b00, 3'b000, 1'b1, 1'b1, 8'b00000000};
      default: return 15'd0;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input logic st, input logic rst, input logic wv, input logic iv,
                      input logic orr, input logic [14:0] e, input logic ld);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.start     = st;
    bus.w_valid   = wv;
    bus.in_valid  = iv;
    bus.out_ready = orr;
    if (ld) begin
      bus.cfg_w_len     = t_w;
      bus.cfg_k_len     = t_k;
      bus.cfg_red_len   = t_r;
      bus.cfg_drain_len = t_d;
    end else begin
      bus.cfg_w_len     = 16'($urandom);
      bus.cfg_k_len     = 16'($urandom);
      bus.cfg_red_len   = 16'($urandom);
      bus.cfg_drain_len = 16'($urandom);
    end
    exp_q.push_back(e);
  endtask

  // masks: bit c set = valid/ready low in the c-th cycle of that phase
  task automatic run_tile(input int w, input int k, input int r, input int d,
                          input logic [31:0] wm, input logic [31:0] km, input logic [31:0] dm,
                          input bit drain_start, input int abort_at);
    int lens[4];
    logic [31:0] masks[4];
    int cyc, beats, c;
    logic v, st, rst;
    logic [14:0] e;
    t_w = w[15:0];
    t_k = k[15:0];
    t_r = r[15:0];
    t_d = d[15:0];
    lens  = '{w, k, r, d};
    masks = '{wm, km, 32'd0, dm};
    step(1'b1, 1'b0, rb(), rb(), rb(), 15'd0, 1'b1);
    cyc = 1;
    for (int p = 0; p < 4; p++) begin
      beats = 0;
      c = 0;
      while (beats < lens[p]) begin
        v   = !masks[p][c];
        e   = ev(p, v);
        rst = (cyc == abort_at);
        st  = rst || (drain_start && p == 3 && c == 0);
        step(st, rst, (p == 0) ? v : rb(), (p == 1) ? v : rb(), (p == 3) ? v : rb(), e, 1'b0);
        if (rst) begin
          step(1'b0, 1'b0, rb(), rb(), rb(), 15'd0, 1'b0);
          step(1'b0, 1'b0, rb(), rb(), rb(), 15'd0, 1'b0);
          return;
        end
        if (v) beats++;
        c++;
        cyc++;
      end
    end
    step(1'b0, 1'b0, rb(), rb(), rb(), ev(4, 1'b0), 1'b0);
    step(1'b0, 1'b0, rb(), rb(), rb(), 15'd0, 1'b0);
  endtask

  initial begin
    reset             = 1'b1;
    bus.start         = 1'b0;
    bus.w_valid       = 1'b0;
    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b0;
    bus.cfg_w_len     = '0;
    bus.cfg_k_len     = '0;
    bus.cfg_red_len   = '0;
    bus.cfg_drain_len = '0;
    repeat (2) @(posedge clk);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 15'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15'd0, 1'b0);

    run_tile(2, 4, 1, 2, 32'd0, 32'd0, 32'd0, 1'b0, -1);
    run_tile(1, 4, 0, 1, 32'd0, 32'b1010, 32'd0, 1'b0, -1);
    run_tile(0, 3, 0, 1, 32'd0, 32'd0, 32'd0, 1'b0, -1);
    run_tile(0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 1'b0, -1);
    run_tile(1, 4, 0, 1, 32'd0, 32'd0, 32'd0, 1'b0, 3);
    run_tile(1, 4, 0, 1, 32'd0, 32'd0, 32'd0, 1'b0, -1);
    run_tile(0, 1, 0, 2, 32'd0, 32'd0, 32'b010, 1'b1, -1);
    run_tile(3, 2, 2, 3, 32'b0110, 32'b1, 32'b11, 1'b0, -1);
    run_tile(0, 0, 3, 0, 32'd0, 32'd0, 32'd0, 1'b0, -1);
    run_tile(20, 0, 0, 0, 32'h0000_8421, 32'd0, 32'd0, 1'b0, -1);
    run_tile(1, 1, 1, 1, 32'd0, 32'd0, 32'd0, 1'b1, -1);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_array_ctrl.md
PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 Params: CNT_W, default 16, width of all length configs and beat counters.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle request to run one tile; honoured only in IDLE.
REQ-005 cfg_w_len, cfg_k_len, cfg_red_len, cfg_drain_len  in  CNT_W each  beat counts for LOAD_W, COMPUTE, REDUCE and DRAIN; sampled on accepted start.
REQ-006 w_valid  in  1  weight beat available; in_valid  in  1  input+random-number beat available; out_ready  in  1  sink accepts drained partial sum.
REQ-007 weight_reg_en, weight_reg_r0w1, input_reg_en, input_reg_r0w1, rand_num_reg_en, rand_num_reg_r0w1, output_num_reg_en, output_num_reg_r0w1  out  1 each  PE register controls, broadcast to the array.
REQ-008 M_end  out  `M_END_BITWIDTH  PE mode: 2'b00 hold, 2'b01 accumulate, 2'b10 add passby.
REQ-009 w_ready, in_ready, out_valid  out  1 each  handshake returns; busy  out  1; done  out  1  one-cycle completion pulse.

Function
REQ-010 FSM states: IDLE, LOAD_W, COMPUTE, REDUCE, DRAIN, DONE; state register plus one shared beat counter (CNT_W bits).
REQ-011 IDLE: all outputs 0, M_end=00; start=1 latches cfgs, clears counter and enters first state whose length is non-zero in order LOAD_W, COMPUTE, REDUCE, DRAIN; if all four are zero, enters DONE.
REQ-012 LOAD_W: w_ready=1; beat accepted when w_valid=1; weight_reg_en=weight_reg_r0w1=w_valid; M_end=00.
REQ-013 COMPUTE: in_ready=1, M_end=01; beat accepted when in_valid=1; input_reg_en/r0w1, rand_num_reg_en/r0w1, output_num_reg_en/r0w1 all equal in_valid; in_valid=0 freezes counter and holds PE accumulators.
REQ-014 REDUCE: M_end=10, output_num_reg_en=output_num_reg_r0w1=1 every cycle; no stall; every cycle is one beat.
REQ-015 DRAIN: out_valid=1, M_end=00, output_num_reg_en=1, output_num_reg_r0w1=0; beat accepted when out_ready=1.
REQ-016 Beat counter increments on each accepted beat; when accepted beat count reaches the state's length, the FSM advances on that same edge to the next non-zero-length state (or DONE) and clears the counter.
REQ-017 DONE: done=1 for exactly one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-018 start outside IDLE is ignored; cfg changes outside IDLE have no effect on the running tile.
REQ-019 Control outputs are combinational decode of state and the relevant valid/ready input; no added latency: a beat presented in cycle n is written by the PE at the edge ending cycle n.
REQ-020 Length value 2^CNT_W-1 is legal; counter never wraps within a state.
REQ-021 Latency with no stalls: start at cycle 0 -> first LOAD_W beat cycle 1 -> done at cycle 1+w+k+r+d.

Reset
REQ-022 reset=1 at any edge forces IDLE, counter 0, latched cfgs 0; all outputs 0 and M_end=00 in the following cycle, including mid-tile.
REQ-023 reset has priority over start in the same cycle.

Structure
REQ-024 Package gemm_ctrl_pkg holds the state enum and M_end encodings (M_HOLD, M_ACC, M_PASS); `M_END_BITWIDTH remains the shared macro.
REQ-025 One sub-module, beat_cnt: CNT_W counter with clear, increment-enable and terminal-count compare against a length input.

Verification
REQ-026 w=2,k=4,r=1,d=2, all valids/readies high, start at cycle 0 -> M_end 01 cycles 3-6, 10 at cycle 7, out_valid cycles 8-9, done cycle 10.
REQ-027 k=4, in_valid low for cycles 2 and 4 of COMPUTE -> exactly 4 cycles with input_reg_en=1, COMPUTE lasts 6 cycles, output_num_reg_en low in stall cycles.
REQ-028 w=0,k=3,r=0,d=1 -> LOAD_W and REDUCE skipped, M_end never 10, done at cycle 5.
REQ-029 All lengths 0 -> done pulse cycle 1, busy high only cycle 1.
REQ-030 reset asserted during COMPUTE beat 2 with start also high -> next cycle IDLE, all outputs 0, no done; new start afterwards runs full tile.
REQ-031 start pulsed again mid-DRAIN, out_ready toggling 1,0,1 with d=2 -> second start ignored, DRAIN lasts 3 cycles, single done.
